// File: rtl/simon_seq_ctrl.sv
// -----------------------------------------------------------------------------
// simon_seq_ctrl
//
// Controller for the Simon memory game. It holds the colour sequence memory,
// a free-running 16-bit Galois LFSR used to draw new colours, a 32-bit phase
// timer and the length/index counters. It sits between the debounced buttons
// and the LED drivers.
//
// Game flow: IDLE -> GEN (draw one colour, grow the sequence) -> alternating
// SHOW_OFF / SHOW_ON playback -> INPUT (player repeats the sequence) -> back to
// GEN on success, or RESULT (win/lose display) -> IDLE.
//
// Ports:
//   CLK    in   1           system clock, rising edge
//   RESET  in   1           synchronous active-high reset
//   START  in   1           start a new game (only honoured in IDLE)
//   BTN    in   NUM_COLORS  one-cycle press pulses from the debouncer
//   LED    out  NUM_COLORS  registered lamp drive
//   LEVEL  out  LW          current sequence length
//   BEST   out  LW          longest sequence fully repeated since RESET
//   WIN    out  1           high during the win display
//   LOSE   out  1           high during the lose display
//   BUSY   out  1           high whenever not IDLE
// -----------------------------------------------------------------------------
module simon_seq_ctrl #(
  parameter int          NUM_COLORS    = 4,
  parameter int          MAX_LEN       = 16,
  parameter int unsigned ON_CYCLES     = 25_000_000,
  parameter int unsigned OFF_CYCLES    = 12_500_000,
  parameter int unsigned RESULT_CYCLES = 50_000_000,
  parameter int unsigned INPUT_TIMEOUT = 250_000_000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  localparam int         CW            = (NUM_COLORS > 2) ? $clog2(NUM_COLORS) : 1,
  localparam int         LW            = $clog2(MAX_LEN + 1)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [NUM_COLORS-1:0] BTN,
  output logic [NUM_COLORS-1:0] LED,
  output logic [LW-1:0]         LEVEL,
  output logic [LW-1:0]         BEST,
  output logic                  WIN,
  output logic                  LOSE,
  output logic                  BUSY
);

  // Timed states load DUR-1 on entry and exit on the edge after reading 0,
  // so each lasts exactly DUR cycles.
  localparam logic [31:0] ON_LOAD     = 32'(ON_CYCLES - 1);
  localparam logic [31:0] OFF_LOAD    = 32'(OFF_CYCLES - 1);
  localparam logic [31:0] RESULT_LOAD = 32'(RESULT_CYCLES - 1);
  localparam logic        TO_EN       = (INPUT_TIMEOUT != 0);
  localparam logic [31:0] TO_LOAD     = TO_EN ? 32'(INPUT_TIMEOUT - 1) : 32'd0;

  // Memory is sized to the full index range of len/idx so every address is
  // in bounds; only the first MAX_LEN entries are ever written.
  localparam int MEM_DEPTH = 1 << LW;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 (right-shifting form).
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_SHOW_OFF,
    S_SHOW_ON,
    S_INPUT,
    S_RESULT
  } state_t;

  state_t                state_q, state_d;
  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         idx_q, idx_d;
  logic [LW-1:0]         best_q, best_d;
  logic [31:0]           timer_q, timer_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [NUM_COLORS-1:0] led_q, led_d;
  logic                  win_q, win_d;
  logic                  lose_q, lose_d;
  logic                  busy_q, busy_d;

  logic [CW-1:0]         mem [MEM_DEPTH];
  logic                  mem_we;
  logic [CW-1:0]         gen_color;
  logic [CW-1:0]         cur_color;
  logic [NUM_COLORS-1:0] cur_onehot;

  assign cur_color = mem[idx_q];

  for (genvar gi = 0; gi < NUM_COLORS; gi++) begin : g_onehot
    assign cur_onehot[gi] = (int'(cur_color) == gi);
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    best_d  = best_q;
    timer_d = timer_q;
    led_d   = led_q;
    win_d   = win_q;
    lose_d  = lose_q;
    mem_we  = 1'b0;

    // LFSR runs in every state, so the drawn colour depends on START timing.
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

    // Fold out-of-range raw values back into 0..NUM_COLORS-1.
    gen_color = lfsr_q[CW-1:0];
    if (int'(gen_color) >= NUM_COLORS) begin
      gen_color = gen_color - CW'(NUM_COLORS);
    end

    case (state_q)
      S_IDLE: begin
        led_d  = '0;
        win_d  = 1'b0;
        lose_d = 1'b0;
        if (START) begin
          len_d   = '0;
          state_d = S_GEN;
        end
      end

      S_GEN: begin
        mem_we  = 1'b1;
        len_d   = len_q + LW'(1);
        idx_d   = '0;
        timer_d = OFF_LOAD;
        led_d   = '0;
        state_d = S_SHOW_OFF;
      end

      S_SHOW_OFF: begin
        led_d = '0;
        if (timer_q == 32'd0) begin
          if (idx_q == len_q) begin
            idx_d   = '0;
            timer_d = TO_LOAD;
            state_d = S_INPUT;
          end else begin
            timer_d = ON_LOAD;
            led_d   = cur_onehot;
            state_d = S_SHOW_ON;
          end
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end

      S_SHOW_ON: begin
        led_d = cur_onehot;
        if (timer_q == 32'd0) begin
          idx_d   = idx_q + LW'(1);
          timer_d = OFF_LOAD;
          led_d   = '0;
          state_d = S_SHOW_OFF;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end

      S_INPUT: begin
        led_d = BTN;
        // A press takes priority over a timeout expiring on the same edge.
        if (BTN != '0) begin
          if (BTN == cur_onehot) begin
            if ((idx_q + LW'(1)) == len_q) begin
              best_d = (len_q > best_q) ? len_q : best_q;
              if (len_q == LW'(MAX_LEN)) begin
                win_d   = 1'b1;
                led_d   = '1;
                timer_d = RESULT_LOAD;
                state_d = S_RESULT;
              end else begin
                led_d   = '0;
                state_d = S_GEN;
              end
            end else begin
              idx_d   = idx_q + LW'(1);
              timer_d = TO_LOAD;
            end
          end else begin
            lose_d  = 1'b1;
            led_d   = '1;
            timer_d = RESULT_LOAD;
            state_d = S_RESULT;
          end
        end else if (TO_EN) begin
          if (timer_q == 32'd0) begin
            lose_d  = 1'b1;
            led_d   = '1;
            timer_d = RESULT_LOAD;
            state_d = S_RESULT;
          end else begin
            timer_d = timer_q - 32'd1;
          end
        end
      end

      S_RESULT: begin
        led_d = '1;
        if (timer_q == 32'd0) begin
          win_d   = 1'b0;
          lose_d  = 1'b0;
          led_d   = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end

      default: begin
        led_d   = '0;
        win_d   = 1'b0;
        lose_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      best_q  <= '0;
      timer_q <= '0;
      lfsr_q  <= LFSR_SEED;
      led_q   <= '0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      best_q  <= best_d;
      timer_q <= timer_d;
      lfsr_q  <= lfsr_d;
      led_q   <= led_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
      busy_q  <= busy_d;
    end
  end

  // Sequence memory is deliberately not cleared by reset.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[len_q] <= gen_color;
    end
  end

  assign LED   = led_q;
  assign LEVEL = len_q;
  assign BEST  = best_q;
  assign WIN   = win_q;
  assign LOSE  = lose_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_simon_seq_ctrl
//
// Directed game scenarios with random START timing against two instances:
//   dut_a: 4 colours, MAX_LEN=3, ON=4, OFF=2, RESULT=3, TIMEOUT=20
//   dut_b: 3 colours, MAX_LEN=1, ON=1, OFF=1, RESULT=1, TIMEOUT=1 (colour fold)
// Expected colours come from a reference LFSR stepped once per clock and the
// colour rule applied to its value in the GEN cycle.
// -----------------------------------------------------------------------------
module tb_simon_seq_ctrl;

  logic       CLK   = 1'b0;
  logic       RESET = 1'b1;

  logic       start_a = 1'b0;
  logic [3:0] btn_a   = 4'b0;
  logic [3:0] led_a;
  logic [1:0] level_a, best_a;
  logic       win_a, lose_a, busy_a;

  logic       start_b = 1'b0;
  logic [2:0] btn_b   = 3'b0;
  logic [2:0] led_b;
  logic [0:0] level_b, best_b;
  logic       win_b, lose_b, busy_b;

  int checks   = 0;
  int failures = 0;

  logic [15:0] lfsr_m;
  int          seq[$];

  always #5 CLK = ~CLK;

  simon_seq_ctrl #(
    .NUM_COLORS(4), .MAX_LEN(3), .ON_CYCLES(4), .OFF_CYCLES(2),
    .RESULT_CYCLES(3), .INPUT_TIMEOUT(20), .LFSR_SEED(16'hACE1)
  ) dut_a (
    .CLK(CLK), .RESET(RESET), .START(start_a), .BTN(btn_a), .LED(led_a),
    .LEVEL(level_a), .BEST(best_a), .WIN(win_a), .LOSE(lose_a), .BUSY(busy_a)
  );

  simon_seq_ctrl #(
    .NUM_COLORS(3), .MAX_LEN(1), .ON_CYCLES(1), .OFF_CYCLES(1),
    .RESULT_CYCLES(1), .INPUT_TIMEOUT(1), .LFSR_SEED(16'hACE1)
  ) dut_b (
    .CLK(CLK), .RESET(RESET), .START(start_b), .BTN(btn_b), .LED(led_b),
    .LEVEL(level_b), .BEST(best_b), .WIN(win_b), .LOSE(lose_b), .BUSY(busy_b)
  );

  // Reference LFSR: polynomial x^16+x^14+x^13+x^11, one step per clock.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] n;
    n = v >> 1;
    if (v[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  always @(posedge CLK) lfsr_m <= RESET ? 16'hACE1 : lfsr_step(lfsr_m);

  // Colour rule: take the low CW bits; values >= n are reduced by n.
  function automatic int colour_of(input logic [15:0] v, input int n);
    int raw;
    raw = (n <= 2) ? int'(v[0]) : (n <= 4) ? int'(v[1:0]) : int'(v[2:0]);
    return (raw >= n) ? raw - n : raw;
  endfunction

  function automatic logic [3:0] onehot4(input int c);
    return 4'b0001 << c;
  endfunction

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge inside the START cycle's following GEN cycle.
  task automatic start_a_game();
    repeat ($urandom_range(0, 7)) tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("gen_busy", 32'(busy_a), 32'd1);
    chk("gen_level_cleared", 32'(level_a), 32'd0);
  endtask

  // Entered at the negedge of a GEN cycle; leaves at the last playback cycle.
  task automatic playback(input int len);
    logic [3:0] exp;
    seq.push_back(colour_of(lfsr_m, 4));
    for (int k = 0; k < 6 * len + 2; k++) begin
      tick();
      exp = ((k < 6 * len) && ((k % 6) >= 2)) ? onehot4(seq[k / 6]) : 4'b0000;
      chk("playback_led", 32'(led_a), 32'(exp));
      if (k == 0) chk("level_after_gen", 32'(level_a), 32'(len));
    end
  endtask

  task automatic press(input logic [3:0] b);
    btn_a = b;
    tick();
    btn_a = 4'b0;
  endtask

  task automatic pulse_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] nx;
    int          c;
    int          n;

    // ---------------- reset and idle ----------------
    RESET = 1'b1;
    repeat (3) tick();
    RESET = 1'b0;
    for (int i = 0; i < 10; i++) begin
      btn_a = 4'($urandom_range(0, 15));
      tick();
      chk("idle_led", 32'(led_a), 32'd0);
      chk("idle_busy", 32'(busy_a), 32'd0);
      chk("idle_level", 32'(level_a), 32'd0);
      chk("idle_best", 32'(best_a), 32'd0);
    end
    btn_a = 4'b0;
    $display("txn reset_idle done");

    // ---------------- perfect game ----------------
    seq.delete();
    start_a_game();
    for (int len = 1; len <= 3; len++) begin
      playback(len);
      tick();  // first INPUT cycle
      if (len == 1) begin
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("start_ignored_level", 32'(level_a), 32'd1);
        chk("start_ignored_busy", 32'(busy_a), 32'd1);
      end
      if (len == 2) begin
        // Press lands on the very edge the timeout would fire: press wins.
        repeat (19) tick();
        chk("tie_pre_lose", 32'(lose_a), 32'd0);
      end
      for (int i = 0; i < len; i++) begin
        press(onehot4(seq[i]));
        if (i < len - 1) begin
          chk("input_echo", 32'(led_a), 32'(onehot4(seq[i])));
          chk("input_no_lose", 32'(lose_a), 32'd0);
        end
      end
      if (len < 3) begin
        chk("round_best", 32'(best_a), 32'(len));
        chk("round_level_hold", 32'(level_a), 32'(len));
        chk("round_no_lose", 32'(lose_a), 32'd0);
      end
    end
    for (int j = 0; j < 3; j++) begin
      chk("win_high", 32'(win_a), 32'd1);
      chk("win_led", 32'(led_a), 32'hF);
      chk("win_best", 32'(best_a), 32'd3);
      chk("win_level", 32'(level_a), 32'd3);
      tick();
    end
    chk("win_cleared", 32'(win_a), 32'd0);
    chk("win_idle_busy", 32'(busy_a), 32'd0);
    chk("win_idle_led", 32'(led_a), 32'd0);
    chk("win_level_held", 32'(level_a), 32'd3);
    $display("txn perfect_game seq=%0d,%0d,%0d", seq[0], seq[1], seq[2]);

    // ---------------- wrong press in round 2 ----------------
    pulse_reset();
    chk("reset_best", 32'(best_a), 32'd0);
    seq.delete();
    start_a_game();
    playback(1);
    tick();
    press(onehot4(seq[0]));
    chk("wrong_r1_best", 32'(best_a), 32'd1);
    playback(2);
    tick();
    press(onehot4(seq[0]));
    press(onehot4((seq[1] + 1) % 4));
    chk("wrong_lose", 32'(lose_a), 32'd1);
    chk("wrong_win", 32'(win_a), 32'd0);
    chk("wrong_level", 32'(level_a), 32'd2);
    chk("wrong_best", 32'(best_a), 32'd1);
    chk("wrong_led", 32'(led_a), 32'hF);
    repeat (2) tick();
    chk("wrong_lose_c3", 32'(lose_a), 32'd1);
    tick();
    chk("wrong_idle_busy", 32'(busy_a), 32'd0);
    chk("wrong_idle_lose", 32'(lose_a), 32'd0);
    chk("wrong_level_held", 32'(level_a), 32'd2);
    $display("txn wrong_press seq=%0d,%0d", seq[0], seq[1]);

    // ---------------- multi-button press ----------------
    seq.delete();
    start_a_game();
    playback(1);
    tick();
    press(4'b0011);
    chk("multi_lose", 32'(lose_a), 32'd1);
    chk("multi_level", 32'(level_a), 32'd1);
    chk("multi_led", 32'(led_a), 32'hF);
    repeat (3) tick();
    chk("multi_idle", 32'(busy_a), 32'd0);
    $display("txn multi_button seq=%0d", seq[0]);

    // ---------------- input timeout ----------------
    seq.delete();
    start_a_game();
    playback(1);
    tick();
    repeat (19) tick();
    chk("timeout_pre", 32'(lose_a), 32'd0);
    tick();
    chk("timeout_lose", 32'(lose_a), 32'd1);
    chk("timeout_led", 32'(led_a), 32'hF);
    repeat (3) tick();
    chk("timeout_idle", 32'(busy_a), 32'd0);
    $display("txn timeout seq=%0d", seq[0]);

    // ---------------- reset abort during SHOW_ON ----------------
    seq.delete();
    start_a_game();
    n = 0;
    while (led_a == 4'b0 && n < 20) begin
      tick();
      n++;
    end
    chk("abort_reached_show_on", 32'(led_a != 4'b0), 32'd1);
    pulse_reset();
    chk("abort_led", 32'(led_a), 32'd0);
    chk("abort_level", 32'(level_a), 32'd0);
    chk("abort_best", 32'(best_a), 32'd0);
    chk("abort_win", 32'(win_a), 32'd0);
    chk("abort_lose", 32'(lose_a), 32'd0);
    chk("abort_busy", 32'(busy_a), 32'd0);
    $display("txn abort");

    // ---------------- colour fold, 3 colours ----------------
    n = 0;
    nx = lfsr_step(lfsr_m);
    while (nx[1:0] != 2'd3 && n < 200) begin
      tick();
      nx = lfsr_step(lfsr_m);
      n++;
    end
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    repeat (2) tick();
    chk("fold_raw3_led", 32'(led_b), 32'b001);
    n = 0;
    while (busy_b && n < 12) begin
      tick();
      n++;
    end
    chk("fold_idle", 32'(busy_b), 32'd0);
    $display("txn colour_fold_forced");

    for (int g = 0; g < 1000; g++) begin
      repeat ($urandom_range(0, 3)) tick();
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      c = colour_of(lfsr_m, 3);
      repeat (2) tick();
      chk("fold_led", 32'(led_b), 32'(3'b001 << c));
      n = 0;
      while (busy_b && n < 12) begin
        tick();
        n++;
      end
      chk("fold_game_idle", 32'(busy_b), 32'd0);
    end
    $display("txn colour_fold_1000_games");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simon_seq_ctrl.md
# simon_seq_ctrl

Parametrised controller for the Simon memory game. It replaces the fixed four-colour state machine and its external counters with a single block that contains:
- the sequence memory,
- the random-colour LFSR,
- the phase timer,
- the index counters.

The block sits between the debounced button front-end and the LED drivers. It supports configurable colour count, sequence depth, phase durations and a player input timeout.

## Interface
Parameters:
- NUM_COLORS, 4, number of buttons/LEDs; legal range 2..8; CW = max(1, $clog2(NUM_COLORS))
- MAX_LEN, 16, longest sequence; reaching it wins; legal range 1..255; LW = $clog2(MAX_LEN+1)
- ON_CYCLES, 25_000_000, cycles each colour is lit during playback (≥1)
- OFF_CYCLES, 12_500_000, dark gap before each playback colour (≥1)
- RESULT_CYCLES, 50_000_000, duration of win/lose display (≥1)
- INPUT_TIMEOUT, 250_000_000, idle cycles allowed per player press; 0 disables the timeout
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
- CLK  in  1  system clock; everything is on the rising edge
- RESET  in  1  synchronous, active-high reset
- START  in  1  begins a new game; honoured only in IDLE
- BTN  in  NUM_COLORS  player press pulses, one cycle each, debounced upstream
- LED  out  NUM_COLORS  lamp drive, registered
- LEVEL  out  LW  current sequence length
- BEST  out  LW  highest LEVEL fully repeated since RESET
- WIN  out  1  high throughout the win display
- LOSE  out  1  high throughout the lose display
- BUSY  out  1  high whenever the state is not IDLE

## Operation
- States: IDLE, GEN, SHOW_OFF, SHOW_ON, INPUT, RESULT.
- Registers: len (LW bits), idx (LW bits), timer (32-bit down-counter), mem[MAX_LEN] of CW bits, lfsr (16 bits).
- LFSR:
  - Galois form, taps x^16+x^14+x^13+x^11.
  - Advances every cycle in every state, so the colour drawn depends on when START arrives.
  - Never zero.
- IDLE: LED=0, WIN=LOSE=0. On START: len←0 → GEN.
- GEN (1 cycle):
  - c = lfsr[CW-1:0]; if c ≥ NUM_COLORS then c ← c − NUM_COLORS.
  - mem[len]←c, len←len+1, idx←0 → SHOW_OFF.
- SHOW_OFF: LED=0 for OFF_CYCLES cycles, then:
  - idx==len → INPUT, idx←0;
  - else → SHOW_ON.
- SHOW_ON: LED=one-hot(mem[idx]) for ON_CYCLES cycles, then idx←idx+1 → SHOW_OFF.
- INPUT: LED mirrors BTN (registered, 1-cycle echo). On a cycle with BTN≠0:
  - BTN == one-hot(mem[idx]):
    - idx+1 < len → idx←idx+1, timeout restarts;
    - idx+1 == len: BEST←max(BEST,len); then len==MAX_LEN → RESULT with WIN, else → GEN.
  - Any other nonzero BTN, including multiple bits set → RESULT with LOSE.
  - INPUT_TIMEOUT>0 and INPUT_TIMEOUT cycles pass with BTN==0 → RESULT with LOSE.
- RESULT:
  - LED all ones; WIN or LOSE high.
  - Lasts RESULT_CYCLES cycles, then → IDLE with WIN/LOSE cleared.
  - LEVEL holds the final len until the next START.
- BTN is ignored outside INPUT. START is ignored outside IDLE.

## Timing
- RESET:
  - Next edge: state=IDLE, LED=0, LEVEL=0, BEST=0, WIN=LOSE=BUSY=0, lfsr=LFSR_SEED, len=idx=timer=0.
  - mem is not cleared.
  - RESET mid-game aborts immediately, with no RESULT phase.
- Phase durations:
  - The timer loads DUR−1 on the edge that enters a timed state.
  - The exit happens on the edge after the timer reads 0, so the state lasts exactly DUR cycles.
- START latency: START sampled at edge N → GEN during cycle N+1 → SHOW_OFF from N+2.
- First lit LED is at edge N+2+OFF_CYCLES.
- Playback of a length-L sequence lasts L·(ON_CYCLES+OFF_CYCLES)+OFF_CYCLES cycles.
- A correct last press at edge M → GEN at M+1; LEVEL increments at M+2.
- A wrong press at edge M → RESULT at M+1 (WIN/LOSE and LED all ones are visible).
- BTN arriving on the same edge as a timeout: the press wins the tie.
- BEST updates on the same edge that leaves INPUT after a complete sequence.

## Test plan
Common parameters: NUM_COLORS=4, MAX_LEN=3, ON=4, OFF=2, RESULT=3, TIMEOUT=20.
- Reset/idle: RESET then 10 idle cycles → LED=0, LEVEL=0, BEST=0, BUSY=0. BTN pulses change nothing.
- Perfect game: START, then replay mem correctly each round. Required:
  - LEVEL steps 1,2,3;
  - playback lengths are 2+6L cycles;
  - WIN high for exactly 3 cycles, LED=4'b1111, then IDLE;
  - BEST=3.
- Wrong press in round 2, second element: drive the non-matching one-hot → next cycle LOSE=1, LEVEL=2, BEST=1; IDLE after 3 cycles.
- Multi-button press: BTN=4'b0011 on the first input → LOSE=1. Timeout case: no press for 20 cycles in INPUT → LOSE=1.
- Colour mapping: NUM_COLORS=3, force lfsr[1:0]=3 at GEN → stored colour 0. Over 1000 games, every stored value is < 3.
- Abort and protocol: RESET asserted during SHOW_ON → IDLE next edge with outputs at reset values. START during INPUT → ignored, len unchanged.
